// File: rtl/seq_alu_param.sv
// Sequential ALU: operands arrive LS-chunk first over an NIB_W-bit bus, then one opcode beat;
// result and NZCV flags are held under a valid/ready handshake. Define SEQ_ALU_MUL_EN for the shift-add multiplier (opcode C).
module seq_alu_param #(
    parameter int DATA_W = 8,
    parameter int NIB_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [NIB_W-1:0]  in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags,
    output logic              busy
);

    localparam int BEATS = DATA_W / NIB_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SH_W  = $clog2(DATA_W);
    localparam int MSB   = DATA_W - 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    // state | meaning: LOAD_A/LOAD_B operand chunks, LOAD_OP opcode, EXEC compute, MUL_RUN shift-add, DONE hold result
    typedef enum logic [2:0] {
        S_LOAD_A,
        S_LOAD_B,
        S_LOAD_OP,
        S_EXEC,
`ifdef SEQ_ALU_MUL_EN
        S_MUL_RUN,
`endif
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [3:0]          op_q, op_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [3:0]          flags_q, flags_d;
    logic                out_valid_q, out_valid_d;

`ifdef SEQ_ALU_MUL_EN
    logic [SH_W-1:0]     mul_cnt_q, mul_cnt_d;
    logic [2*DATA_W-1:0] mul_acc_q, mul_acc_d;
    logic [2*DATA_W-1:0] mul_mcand_q, mul_mcand_d;
    logic [DATA_W-1:0]   mul_mplier_q, mul_mplier_d;
    logic [2*DATA_W-1:0] acc_next;
`endif

    logic [DATA_W-1:0]        alu_res;
    logic [3:0]               alu_flags;
    logic [DATA_W:0]          sum, diff, shl_ext, shr_ext;
    logic signed [DATA_W:0]   asr_src, asr_ext;
    logic [SH_W-1:0]          sh;
    logic                     add_v, sub_v, c_bit, v_bit, is_cmp;

    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        diff    = {1'b0, a_q} - {1'b0, b_q};
        sh      = b_q[SH_W-1:0];
        shl_ext = {1'b0, a_q} << sh;
        shr_ext = {a_q, 1'b0} >> sh;
        asr_src = {a_q, 1'b0};
        asr_ext = asr_src >>> sh;
        add_v   = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
        sub_v   = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
        alu_res = sum[DATA_W-1:0];
        c_bit   = sum[DATA_W];
        v_bit   = add_v;
        is_cmp  = 1'b0;
        case (op_q)
            4'h1: begin alu_res = diff[DATA_W-1:0]; c_bit = diff[DATA_W]; v_bit = sub_v; end
            4'h2: begin alu_res = a_q & b_q;    c_bit = 1'b0; v_bit = 1'b0; end
            4'h3: begin alu_res = a_q | b_q;    c_bit = 1'b0; v_bit = 1'b0; end
            4'h4: begin alu_res = ~a_q;         c_bit = 1'b0; v_bit = 1'b0; end
            4'h5: begin alu_res = ~(a_q & b_q); c_bit = 1'b0; v_bit = 1'b0; end
            4'h6: begin alu_res = ~(a_q | b_q); c_bit = 1'b0; v_bit = 1'b0; end
            4'h7: begin alu_res = a_q ^ b_q;    c_bit = 1'b0; v_bit = 1'b0; end
            // shifts carry out the last bit that fell off; a zero shift leaves it 0
            4'h8: begin alu_res = shl_ext[DATA_W-1:0]; c_bit = shl_ext[DATA_W]; v_bit = 1'b0; end
            4'h9: begin alu_res = shr_ext[DATA_W:1];   c_bit = shr_ext[0];      v_bit = 1'b0; end
            4'hA: begin alu_res = asr_ext[DATA_W:1];   c_bit = asr_ext[0];      v_bit = 1'b0; end
            4'hB: begin alu_res = a_q; c_bit = diff[DATA_W]; v_bit = sub_v; is_cmp = 1'b1; end
            default: ;
        endcase
        alu_flags = {is_cmp ? diff[MSB] : alu_res[MSB],
                     is_cmp ? (a_q == b_q) : (alu_res == '0),
                     c_bit, v_bit};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
`ifdef SEQ_ALU_MUL_EN
        mul_cnt_d    = mul_cnt_q;
        mul_acc_d    = mul_acc_q;
        mul_mcand_d  = mul_mcand_q;
        mul_mplier_d = mul_mplier_q;
        acc_next     = mul_acc_q + (mul_mplier_q[0] ? mul_mcand_q : '0);
`endif
        case (state_q)
            S_LOAD_A, S_LOAD_B: begin
                if (in_valid) begin
                    for (int k = 0; k < BEATS; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            if (state_q == S_LOAD_A) a_d[k*NIB_W +: NIB_W] = in_data;
                            else                     b_d[k*NIB_W +: NIB_W] = in_data;
                        end
                    end
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_LOAD_OP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_LOAD_OP: begin
                if (in_valid) begin
                    op_d    = in_data[3:0];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
`ifdef SEQ_ALU_MUL_EN
                if (op_q == 4'hC) begin
                    mul_cnt_d    = '0;
                    mul_acc_d    = '0;
                    mul_mcand_d  = {{DATA_W{1'b0}}, a_q};
                    mul_mplier_d = b_q;
                    state_d      = S_MUL_RUN;
                end else begin
                    result_d    = alu_res;
                    flags_d     = alu_flags;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
`else
                result_d    = alu_res;
                flags_d     = alu_flags;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
`endif
            end
`ifdef SEQ_ALU_MUL_EN
            S_MUL_RUN: begin
                mul_acc_d    = acc_next;
                mul_mcand_d  = mul_mcand_q << 1;
                mul_mplier_d = mul_mplier_q >> 1;
                mul_cnt_d    = mul_cnt_q + 1'b1;
                if (mul_cnt_q == SH_W'(DATA_W - 1)) begin
                    result_d    = acc_next[DATA_W-1:0];
                    flags_d     = {acc_next[MSB], (acc_next[DATA_W-1:0] == '0),
                                   |acc_next[2*DATA_W-1:DATA_W], 1'b0};
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_LOAD_A;
                end
            end
            default: state_d = S_LOAD_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_LOAD_A;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            mul_cnt_q    <= '0;
            mul_acc_q    <= '0;
            mul_mcand_q  <= '0;
            mul_mplier_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
`ifdef SEQ_ALU_MUL_EN
            mul_cnt_q    <= mul_cnt_d;
            mul_acc_q    <= mul_acc_d;
            mul_mcand_q  <= mul_mcand_d;
            mul_mplier_q <= mul_mplier_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B) || (state_q == S_LOAD_OP);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign busy      = (state_q != S_LOAD_A) || (cnt_q != '0);

endmodule

// File: tb/tb_seq_alu_param.sv
// Scoreboard bench for seq_alu_param (DATA_W=8, NIB_W=4): driver pushes expected results,
// a negedge monitor checks latency, result and flags on every out_valid cycle.
module tb_seq_alu_param;

    localparam int DW = 8;
    localparam int NW = 4;
    localparam int BEATS = DW / NW;

    logic          clk, reset, in_valid, in_ready, out_valid, out_ready, busy;
    logic [NW-1:0] in_data;
    logic [DW-1:0] result;
    logic [3:0]    flags;

    seq_alu_param #(.DATA_W(DW), .NIB_W(NW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .busy(busy)
    );

    typedef struct {
        logic [DW-1:0] res;
        logic [3:0]    flg;
        int            op_cyc;
        int            lat;
    } exp_t;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [3:0]    op;
        logic [DW-1:0] r;
        logic [3:0]    f;
    } vec_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic prev_ov = 1'b0;

    // flags are {N,Z,C,V}
    vec_t vecs [18] = '{
        '{8'hF0, 8'h20, 4'h0, 8'h10, 4'b0010},
        '{8'h05, 8'h07, 4'h1, 8'hFE, 4'b1010},
        '{8'h80, 8'h01, 4'h1, 8'h7F, 4'b0001},
        '{8'h33, 8'h33, 4'hB, 8'h33, 4'b0100},
        '{8'h81, 8'h01, 4'h8, 8'h02, 4'b0010},
        '{8'h81, 8'h01, 4'hA, 8'hC0, 4'b1010},
        '{8'h81, 8'h00, 4'h8, 8'h81, 4'b1000},
        '{8'h81, 8'h08, 4'hA, 8'h81, 4'b1000},
        '{8'h81, 8'h01, 4'h9, 8'h40, 4'b0010},
        '{8'hF0, 8'h3C, 4'h2, 8'h30, 4'b0000},
        '{8'hF0, 8'h3C, 4'h3, 8'hFC, 4'b1000},
        '{8'h0F, 8'h55, 4'h4, 8'hF0, 4'b1000},
        '{8'hF0, 8'h3C, 4'h5, 8'hCF, 4'b1000},
        '{8'hF0, 8'h0F, 4'h6, 8'h00, 4'b0100},
        '{8'hF0, 8'h3C, 4'h7, 8'hCC, 4'b1000},
        '{8'h7F, 8'h01, 4'h0, 8'h80, 4'b1001},
        '{8'h05, 8'h07, 4'hB, 8'h05, 4'b1010},
        '{8'h10, 8'h20, 4'hE, 8'h30, 4'b0000}
    };

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: compare every cycle the output is presented, pop when out_valid drops
    always @(negedge clk) begin
        if (reset) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_out_valid: got result 0x%0h with no expected entry", result);
                end else begin
                    if (!prev_ov) chk("latency", 32'(cyc - q[0].op_cyc), 32'(q[0].lat));
                    chk("result", 32'(result), 32'(q[0].res));
                    chk("flags", 32'(flags), 32'(q[0].flg));
                end
            end else if (prev_ov && q.size() > 0) begin
                void'(q.pop_front());
            end
            prev_ov = out_valid;
        end
    end

    // called at a negedge; returns at the negedge after the beat is taken
    task automatic send_beat(input logic [NW-1:0] d, output int acc_cyc);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL beat_timeout: got in_ready 0, expected 1 within 100 cycles");
        end
        acc_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic gap(input bit rnd);
        int n;
        n = rnd ? int'($urandom_range(0, 3)) : 0;
        repeat (n) begin
            in_valid = 1'b0;
            in_data  = NW'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] op,
                          input logic [DW-1:0] r, input logic [3:0] f, input int lat, input bit rnd);
        int   c;
        exp_t e;
        for (int k = 0; k < BEATS; k++) begin gap(rnd); send_beat(a[k*NW +: NW], c); end
        for (int k = 0; k < BEATS; k++) begin gap(rnd); send_beat(b[k*NW +: NW], c); end
        gap(rnd);
        send_beat(NW'(op), c);
        e.res = r; e.flg = f; e.op_cyc = c; e.lat = lat;
        q.push_back(e);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((q.size() != 0 || out_valid) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() != 0 || out_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: got %0d pending results, expected 0", q.size());
        end
    endtask

    initial begin
        int c;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].r, vecs[i].f, 2, 1'b0);
        wait_idle();

        // random beat gaps, then a stalled consumer with junk on the input bus
        out_ready = 1'b0;
        run_op(8'hA5, 8'h3C, 4'h7, 8'h99, 4'b1000, 2, 1'b1);
        c = 0;
        while (!out_valid && c < 20) begin @(negedge clk); c++; end
        repeat (5) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = NW'($urandom);
            chk("stall_in_ready", 32'(in_ready), 32'h0);
            chk("stall_busy", 32'(busy), 32'h1);
            chk("stall_out_valid", 32'(out_valid), 32'h1);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        run_op(8'h11, 8'h22, 4'h0, 8'h33, 4'b0000, 2, 1'b0);
        wait_idle();

        // reset in the middle of loading B
        send_beat(4'h3, c);
        send_beat(4'hC, c);
        send_beat(4'h7, c);
        chk("midload_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst2_result", 32'(result), 32'h0);
        chk("rst2_flags", 32'(flags), 32'h0);
        chk("rst2_out_valid", 32'(out_valid), 32'h0);
        chk("rst2_in_ready", 32'(in_ready), 32'h1);
        chk("rst2_busy", 32'(busy), 32'h0);
        run_op(8'h01, 8'h01, 4'h0, 8'h02, 4'b0000, 2, 1'b0);
        wait_idle();

`ifdef SEQ_ALU_MUL_EN
        run_op(8'h12, 8'h10, 4'hC, 8'h20, 4'b0010, DW + 2, 1'b0);
`else
        run_op(8'h12, 8'h10, 4'hC, 8'h22, 4'b0000, 2, 1'b0);
`endif
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
